// File: rtl/imm_gen.sv
// RV32I decode-stage immediate generator: all five formats in parallel,
// opcode-selected immediate, and an optional registered copy for execute.
//
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   instruction    raw 32-bit instruction word
//   i/s/b/u/j_imm  sign-extended immediates, always computed
//   imm_fmt        decoded format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//   imm_out        immediate picked by imm_fmt (zero for NONE)
//   imm_q, fmt_q   registered imm_out / imm_fmt
//
// Build option IMM_GEN_OUT_REG_EN:
//   defined   -> imm_q/fmt_q are flops with one-cycle latency
//   undefined -> imm_q/fmt_q follow imm_out/imm_fmt combinationally
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] s_imm,
    output logic [XLEN-1:0] b_imm,
    output logic [XLEN-1:0] u_imm,
    output logic [XLEN-1:0] j_imm,
    output logic [2:0]      imm_fmt,
    output logic [XLEN-1:0] imm_out,
    output logic [XLEN-1:0] imm_q,
    output logic [2:0]      fmt_q
);

    generate
        if (XLEN != 32) begin : g_xlen_chk
            $error("imm_gen: only XLEN=32 is supported");
        end
    endgenerate

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic        sgn;
    fmt_e        fmt;

    assign ins    = instruction;
    assign opcode = ins[6:0];
    assign sgn    = ins[31];

    assign i_imm = {{20{sgn}}, ins[31:20]};
    assign s_imm = {{20{sgn}}, ins[31:25], ins[11:7]};
    assign b_imm = {{19{sgn}}, ins[31], ins[7],
                    ins[30:25], ins[11:8], 1'b0};
    assign u_imm = {ins[31:12], 12'h000};
    assign j_imm = {{11{sgn}}, ins[31], ins[19:12],
                    ins[20], ins[30:21], 1'b0};

    always_comb begin
        fmt = FMT_NONE;
        case (opcode)
            7'b0010011: fmt = FMT_I;  // OP-IMM
            7'b0000011: fmt = FMT_I;  // LOAD
            7'b1100111: fmt = FMT_I;  // JALR
            7'b1110011: fmt = FMT_I;  // SYSTEM
            7'b0100011: fmt = FMT_S;  // STORE
            7'b1100011: fmt = FMT_B;  // BRANCH
            7'b0110111: fmt = FMT_U;  // LUI
            7'b0010111: fmt = FMT_U;  // AUIPC
            7'b1101111: fmt = FMT_J;  // JAL
            default:    fmt = FMT_NONE;
        endcase
    end

    assign imm_fmt = fmt;

    always_comb begin
        imm_out = '0;
        case (fmt)
            FMT_I:   imm_out = i_imm;
            FMT_S:   imm_out = s_imm;
            FMT_B:   imm_out = b_imm;
            FMT_U:   imm_out = u_imm;
            FMT_J:   imm_out = j_imm;
            default: imm_out = '0;
        endcase
    end

`ifdef IMM_GEN_OUT_REG_EN
    logic [XLEN-1:0] imm_d;
    logic [2:0]      fmt_d;

    assign imm_d = imm_out;
    assign fmt_d = imm_fmt;

    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q <= '0;
            fmt_q <= 3'd0;
        end else begin
            imm_q <= imm_d;
            fmt_q <= fmt_d;
        end
    end
`else
    // Pass-through build: clk/rst have no loads.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign imm_q = imm_out;
    assign fmt_q = imm_fmt;
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Randomized scoreboard bench for imm_gen: stimulus pushes expected
// responses, a negedge monitor pops and compares against the DUT.
module tb_imm_gen;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [2:0]  imm_fmt;
    logic [31:0] imm_out;
    logic [31:0] imm_q;
    logic [2:0]  fmt_q;

    imm_gen #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .i_imm       (i_imm),
        .s_imm       (s_imm),
        .b_imm       (b_imm),
        .u_imm       (u_imm),
        .j_imm       (j_imm),
        .imm_fmt     (imm_fmt),
        .imm_out     (imm_out),
        .imm_q       (imm_q),
        .fmt_q       (fmt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        rst;
        logic [31:0] ei, es, eb, eu, ej;
        logic [2:0]  efmt;
        logic [31:0] eout;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model: immediates rebuilt from field weights.
    function automatic int sext(logic [31:0] w);
        return w[31] ? -1 : 0;
    endfunction

    function automatic logic [31:0] m_i(logic [31:0] w);
        return 32'(sext(w) * 4096 + int'(w[31:20]) - int'(w[31]) * 2048 * 2
                   + (w[31] ? 4096 : 0));
    endfunction

    function automatic logic [31:0] m_s(logic [31:0] w);
        int hi;
        hi = int'(w[30:25]) + (w[31] ? -64 : 0);
        return 32'(hi * 32 + int'(w[11:7]));
    endfunction

    function automatic logic [31:0] m_b(logic [31:0] w);
        return 32'(sext(w) * 4096 + int'(w[7]) * 2048
                   + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
    endfunction

    function automatic logic [31:0] m_u(logic [31:0] w);
        return (w / 32'd4096) * 32'd4096;
    endfunction

    function automatic logic [31:0] m_j(logic [31:0] w);
        return 32'(sext(w) * 1048576 + int'(w[19:12]) * 4096
                   + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
    endfunction

    function automatic logic [2:0] m_fmt(logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op inside {7'h13, 7'h03, 7'h67, 7'h73}) return 3'd1;
        if (op == 7'h23) return 3'd2;
        if (op == 7'h63) return 3'd3;
        if (op inside {7'h37, 7'h17}) return 3'd4;
        if (op == 7'h6F) return 3'd5;
        return 3'd0;
    endfunction

    function automatic item_t mk(logic [31:0] w, logic r);
        item_t it;
        it.ins  = w;
        it.rst  = r;
        it.ei   = m_i(w);
        it.es   = m_s(w);
        it.eb   = m_b(w);
        it.eu   = m_u(w);
        it.ej   = m_j(w);
        it.efmt = m_fmt(w);
        case (it.efmt)
            3'd1:    it.eout = it.ei;
            3'd2:    it.eout = it.es;
            3'd3:    it.eout = it.eb;
            3'd4:    it.eout = it.eu;
            3'd5:    it.eout = it.ej;
            default: it.eout = 32'h0;
        endcase
        return it;
    endfunction

    task automatic chk(string name, logic [31:0] ins,
                       logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ins=%h got=%h want=%h", name, ins, act, exp);
        end
    endtask

    // Monitor
    logic [31:0] reg_imm;
    logic [2:0]  reg_fmt;
    logic        reg_vld;

    initial begin
        item_t it;
        reg_vld = 1'b0;
        reg_imm = '0;
        reg_fmt = '0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                chk("i_imm", it.ins, i_imm, it.ei);
                chk("s_imm", it.ins, s_imm, it.es);
                chk("b_imm", it.ins, b_imm, it.eb);
                chk("u_imm", it.ins, u_imm, it.eu);
                chk("j_imm", it.ins, j_imm, it.ej);
                chk("imm_fmt", it.ins, 32'(imm_fmt), 32'(it.efmt));
                chk("imm_out", it.ins, imm_out, it.eout);
`ifdef IMM_GEN_OUT_REG_EN
                if (reg_vld) begin
                    chk("imm_q", it.ins, imm_q, reg_imm);
                    chk("fmt_q", it.ins, 32'(fmt_q), 32'(reg_fmt));
                end
                reg_vld = 1'b1;
                reg_imm = it.rst ? 32'h0 : it.eout;
                reg_fmt = it.rst ? 3'd0 : it.efmt;
`else
                chk("imm_q", it.ins, imm_q, it.eout);
                chk("fmt_q", it.ins, 32'(fmt_q), 32'(it.efmt));
`endif
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] dir [6];
        logic [6:0]  ops [10];
        logic [31:0] w;
        logic        r;

        dir[0] = 32'h7FF00093;
        dir[1] = 32'hFFF00093;
        dir[2] = 32'h00110123;
        dir[3] = 32'h123450B7;
        dir[4] = 32'h0100006F;
        dir[5] = 32'h00000000;

        ops[0] = 7'h13; ops[1] = 7'h03; ops[2] = 7'h67;
        ops[3] = 7'h73; ops[4] = 7'h23; ops[5] = 7'h63;
        ops[6] = 7'h37; ops[7] = 7'h17; ops[8] = 7'h6F;
        ops[9] = 7'h33;

        rst = 1'b1;
        instruction = 32'h0;

        @(posedge clk); #1;
        rst = 1'b1;
        instruction = 32'hFFFFFFFF;
        sb.push_back(mk(instruction, 1'b1));

        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            instruction = dir[k];
            sb.push_back(mk(dir[k], 1'b0));
        end

        for (int k = 0; k < 400; k++) begin
            w = $urandom;
            if ($urandom_range(0, 3) != 0)
                w[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0)
                w[31] = ~w[31];
            r = (k == 200 || k == 201);
            @(posedge clk); #1;
            rst = r;
            instruction = w;
            sb.push_back(mk(w, r));
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++)
            @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
